// File: rtl/ram_loader.sv
// Bus initiator for the 16x8 program/data RAM: LOAD fills it from a byte stream, DUMP
// streams every location back out. Optional trailing checksum on LOAD: RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              load_error,
  output logic [2:0]        fsm_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] L_WAIT  = 3'd1;
  localparam logic [2:0] L_WRITE = 3'd2;
  localparam logic [2:0] D_ADDR  = 3'd3;
  localparam logic [2:0] D_WAIT  = 3'd4;
  localparam logic [2:0] D_OUT   = 3'd5;
  localparam logic [2:0] FIN     = 3'd6;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] L_CSUM  = 3'd7;
`endif

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              last;

  assign ptr_next = ptr + 1'b1;
  assign last     = (ptr == ADDR_W'(DEPTH - 1));

  // Stream handshakes: a byte moves on a rising edge where valid and ready are both 1;
  // the sender holds data/valid stable until then, and ready never depends on valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      ram_address <= '0;
      ram_data_in <= '0;
      out_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= L_WAIT;
            ptr   <= '0;
          end else if (dump_start) begin
            state       <= D_ADDR;
            ptr         <= '0;
            ram_address <= '0;
          end
        end
        L_WAIT: begin
          if (in_valid) begin
            ram_data_in <= in_data;
            ram_address <= ptr;
            state       <= L_WRITE;
          end
        end
        L_WRITE: begin
          if (last) begin
`ifdef RAM_LOADER_CHECKSUM_EN
            state <= L_CSUM;
`else
            state <= FIN;
`endif
          end else begin
            ptr   <= ptr_next;
            state <= L_WAIT;
          end
        end
        // Address is already on the bus here; the RAM samples it on leaving D_ADDR.
        D_ADDR: state <= D_WAIT;
        D_WAIT: begin
          out_data <= ram_data_out;
          state    <= D_OUT;
        end
        D_OUT: begin
          if (out_ready) begin
            if (last) begin
              state <= FIN;
            end else begin
              ptr         <= ptr_next;
              ram_address <= ptr_next;
              state       <= D_ADDR;
            end
          end
        end
        FIN: state <= IDLE;
`ifdef RAM_LOADER_CHECKSUM_EN
        L_CSUM: begin
          if (in_valid) state <= FIN;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  // The checksum byte is compared against the sum of the data bytes only and never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum        <= '0;
      load_error <= 1'b0;
    end else if (state == IDLE && load_start) begin
      sum        <= '0;
      load_error <= 1'b0;
    end else if (state == L_WAIT && in_valid) begin
      sum <= sum + in_data;
    end else if (state == L_CSUM && in_valid) begin
      load_error <= (in_data != sum);
    end
  end
`else
  assign load_error = 1'b0;
`endif

  always_comb begin
    in_ready = (state == L_WAIT);
`ifdef RAM_LOADER_CHECKSUM_EN
    if (state == L_CSUM) in_ready = 1'b1;
`endif
  end

  assign ram_write_enable = (state == L_WRITE);
  assign out_valid        = (state == D_OUT);
  assign done             = (state == FIN);
  assign busy             = (state != IDLE);
  assign cpu_halt         = (state != IDLE);
  assign fsm_state        = state;

endmodule
